axi_slv_w_order_sched: RTL and testbench

Write-data scheduler on the slave side of the AXI3 crossbar. It records the master index and burst length of each AW transfer accepted by the slave, in acceptance order. It then forwards whole W bursts from the matching master to the slave in that same order, with no interleaving. It generates WLAST from its own beat count and checks each master's WLAST against that count.

---
 rtl/axi_xbar_pkg.sv | 23 ++
 rtl/axi_ostd_fifo.sv | 71 +++++++
 rtl/axi_slv_w_order_sched.sv | 137 +++++++++++++
 tb/tb_axi_slv_w_order_sched.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_xbar_pkg.sv
// Shared types for the AXI3 crossbar slave-side logic.
//   len_t          : AXLEN burst length field (beats-1)
//   mst_idx_t      : upstream master index, sized from XBAR_MST_NUM
//   w_order_ent_t  : one AW order record {mst, len}
package axi_xbar_pkg;

  localparam int unsigned XBAR_MST_NUM = 4;
  localparam int unsigned MST_IDX_W    = (XBAR_MST_NUM > 1) ? $clog2(XBAR_MST_NUM) : 1;

  typedef logic [3:0]           len_t;
  typedef logic [MST_IDX_W-1:0] mst_idx_t;

  typedef struct packed {
    mst_idx_t mst;
    len_t     len;
  } w_order_ent_t;

  // True when the beat about to be transferred is the final one of the burst.
  function automatic logic is_last_beat(input len_t beat_cnt, input len_t len);
    return beat_cnt == len;
  endfunction

endpackage

// File: rtl/axi_ostd_fifo.sv
// Synchronous FIFO holding outstanding AW order records.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write request / data (ignored while full)
//   pop        : read request (ignored while empty)
//   dout       : head entry, valid while !empty
//   count      : number of occupied entries
//   full/empty : occupancy flags
// No bypass: a pushed entry is visible at dout no earlier than the next cycle.
module axi_ostd_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/axi_slv_w_order_sched.sv
// Slave-side W scheduler for the AXI3 crossbar.
// Records {master, AWLEN} of each AW accepted by the slave and forwards whole
// W bursts from those masters to the slave in the same order, never
// interleaving. WLAST toward the slave comes from an internal beat count;
// each master's WLAST is only compared against it (sticky wlast_err).
//   aw_push_*        : AW acceptance record in, aw_push_ready = order FIFO has room
//   in_w*            : per-master W channels, flattened, master 0 in LSBs
//   out_wready_mst   : per-master WREADY (one-hot on the selected master)
//   out_w*/in_wready : slave W channel
//   ostd_cnt         : occupied order FIFO entries
//   wlast_err        : sticky WLAST disagreement flag
module axi_slv_w_order_sched
  import axi_xbar_pkg::*;
#(
  parameter int unsigned MST_NUM    = 4,
  parameter int unsigned OSTD_NUM   = 4,
  parameter int unsigned AXI_ID_W   = 4,
  parameter int unsigned AXI_DATA_W = 32,
  localparam int unsigned MST_W  = $clog2(MST_NUM),
  localparam int unsigned STRB_W = AXI_DATA_W / 8,
  localparam int unsigned CNT_W  = $clog2(OSTD_NUM) + 1
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         aw_push_valid,
  input  logic [MST_W-1:0]             aw_push_mst,
  input  logic [3:0]                   aw_push_len,
  output logic                         aw_push_ready,
  input  logic [MST_NUM-1:0]           in_wvalid,
  input  logic [MST_NUM-1:0]           in_wlast,
  input  logic [MST_NUM*AXI_ID_W-1:0]  in_wid,
  input  logic [MST_NUM*AXI_DATA_W-1:0] in_wdata,
  input  logic [MST_NUM*STRB_W-1:0]    in_wstrb,
  output logic [MST_NUM-1:0]           out_wready_mst,
  output logic                         out_wvalid,
  output logic                         out_wlast,
  output logic [AXI_ID_W-1:0]          out_wid,
  output logic [AXI_DATA_W-1:0]        out_wdata,
  output logic [STRB_W-1:0]            out_wstrb,
  input  logic                         in_wready,
  output logic [CNT_W-1:0]             ostd_cnt,
  output logic                         wlast_err
);

  localparam int unsigned ENT_W = $bits(w_order_ent_t);

  w_order_ent_t     push_ent;
  w_order_ent_t     head_ent;
  logic [ENT_W-1:0] fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic             head_vld;
  logic             aw_push;
  logic             sel_wlast;
  logic             beat_acc;
  logic             burst_pop;

  logic             rdy_q, rdy_d;
  len_t             beat_cnt_q, beat_cnt_d;
  logic             wlast_err_q, wlast_err_d;

  // rdy_q holds aw_push_ready low during reset and rises one clock after release.
  assign aw_push_ready = rdy_q & ~fifo_full;
  assign aw_push       = aw_push_valid & aw_push_ready;
  assign push_ent.mst  = mst_idx_t'(aw_push_mst);
  assign push_ent.len  = aw_push_len;
  assign head_ent      = w_order_ent_t'(fifo_dout);
  assign head_vld      = ~fifo_empty;
  assign wlast_err     = wlast_err_q;

  axi_ostd_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (OSTD_NUM)
  ) u_order_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (aw_push),
    .din   (push_ent),
    .pop   (burst_pop),
    .dout  (fifo_dout),
    .count (ostd_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // W mux: only the head master's lanes reach the slave; nothing depends on
  // aw_push_*, so there is no AW-to-W combinational path.
  always_comb begin
    out_wvalid     = 1'b0;
    out_wid        = '0;
    out_wdata      = '0;
    out_wstrb      = '0;
    out_wready_mst = '0;
    sel_wlast      = 1'b0;
    if (head_vld) begin
      for (int unsigned i = 0; i < MST_NUM; i++) begin
        if (32'(head_ent.mst) == i) begin
          out_wvalid        = in_wvalid[i];
          sel_wlast         = in_wlast[i];
          out_wid           = in_wid[i*AXI_ID_W +: AXI_ID_W];
          out_wdata         = in_wdata[i*AXI_DATA_W +: AXI_DATA_W];
          out_wstrb         = in_wstrb[i*STRB_W +: STRB_W];
          out_wready_mst[i] = in_wready;
        end
      end
    end
    out_wlast = out_wvalid & is_last_beat(beat_cnt_q, head_ent.len);
  end

  assign beat_acc  = out_wvalid & in_wready;
  assign burst_pop = beat_acc & out_wlast;

  always_comb begin
    rdy_d       = 1'b1;
    beat_cnt_d  = beat_cnt_q;
    wlast_err_d = wlast_err_q;
    if (burst_pop) begin
      beat_cnt_d = '0;
    end else if (beat_acc) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
    if (beat_acc && (sel_wlast != out_wlast)) wlast_err_d = 1'b1;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_q       <= 1'b0;
      beat_cnt_q  <= '0;
      wlast_err_q <= 1'b0;
    end else begin
      rdy_q       <= rdy_d;
      beat_cnt_q  <= beat_cnt_d;
      wlast_err_q <= wlast_err_d;
    end
  end

endmodule

// File: tb/tb_axi_slv_w_order_sched.sv
module tb_axi_slv_w_order_sched;

  localparam int MST  = 4;
  localparam int OSTD = 4;
  localparam int IDW  = 4;
  localparam int DW   = 32;
  localparam int SW   = DW / 8;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b1;
  logic              aw_push_valid;
  logic [1:0]        aw_push_mst;
  logic [3:0]        aw_push_len;
  logic              aw_push_ready;
  logic [MST-1:0]    in_wvalid;
  logic [MST-1:0]    in_wlast;
  logic [MST*IDW-1:0] in_wid;
  logic [MST*DW-1:0] in_wdata;
  logic [MST*SW-1:0] in_wstrb;
  logic [MST-1:0]    out_wready_mst;
  logic              out_wvalid;
  logic              out_wlast;
  logic [IDW-1:0]    out_wid;
  logic [DW-1:0]     out_wdata;
  logic [SW-1:0]     out_wstrb;
  logic              in_wready;
  logic [2:0]        ostd_cnt;
  logic              wlast_err;

  always #5 aclk = ~aclk;

  axi_slv_w_order_sched #(
    .MST_NUM    (MST),
    .OSTD_NUM   (OSTD),
    .AXI_ID_W   (IDW),
    .AXI_DATA_W (DW)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .aw_push_valid  (aw_push_valid),
    .aw_push_mst    (aw_push_mst),
    .aw_push_len    (aw_push_len),
    .aw_push_ready  (aw_push_ready),
    .in_wvalid      (in_wvalid),
    .in_wlast       (in_wlast),
    .in_wid         (in_wid),
    .in_wdata       (in_wdata),
    .in_wstrb       (in_wstrb),
    .out_wready_mst (out_wready_mst),
    .out_wvalid     (out_wvalid),
    .out_wlast      (out_wlast),
    .out_wid        (out_wid),
    .out_wdata      (out_wdata),
    .out_wstrb      (out_wstrb),
    .in_wready      (in_wready),
    .ostd_cnt       (ostd_cnt),
    .wlast_err      (wlast_err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit auto_wlast = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Queue of AW records in acceptance order; 'done' = beats already sent of
  // the head burst; 'merr' = sticky WLAST disagreement; 'mup' = out of reset
  // for at least one clock.
  typedef struct {int mst; int len;} ent_t;
  ent_t mq[$];
  int   done = 0;
  bit   merr = 1'b0;
  bit   mup  = 1'b0;

  always @(posedge aclk or negedge aresetn) begin
    int  sz0;
    int  m;
    bit  acc;
    bit  last;
    ent_t e;
    if (!aresetn) begin
      mq.delete();
      done = 0;
      merr = 1'b0;
      mup  = 1'b0;
    end else begin
      sz0  = mq.size();
      acc  = 1'b0;
      last = 1'b0;
      if (sz0 > 0) begin
        m    = mq[0].mst;
        acc  = in_wvalid[m] && in_wready;
        last = (done == mq[0].len);
        if (acc && (in_wlast[m] != last)) merr = 1'b1;
      end
      if (acc) begin
        if (last) begin
          void'(mq.pop_front());
          done = 0;
        end else begin
          done++;
        end
      end
      if (aw_push_valid) begin
        check("push_only_when_ready", {63'd0, (mup && sz0 < OSTD)}, 64'd1);
        if (mup && sz0 < OSTD) begin
          e.mst = int'(aw_push_mst);
          e.len = int'(aw_push_len);
          mq.push_back(e);
        end
      end
      mup = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge aclk) begin
    logic           ev, el, epr;
    logic [MST-1:0] erdy;
    logic [IDW-1:0] eid;
    logic [DW-1:0]  edata;
    logic [SW-1:0]  estrb;
    int             m;
    ev = 1'b0; el = 1'b0; erdy = '0; eid = '0; edata = '0; estrb = '0;
    if (mq.size() > 0) begin
      m       = mq[0].mst;
      ev      = in_wvalid[m];
      el      = ev && (done == mq[0].len);
      erdy[m] = in_wready;
      eid     = in_wid[m*IDW +: IDW];
      edata   = in_wdata[m*DW +: DW];
      estrb   = in_wstrb[m*SW +: SW];
    end
    epr = mup && (mq.size() < OSTD);
    check("out_wvalid", out_wvalid, ev);
    check("out_wlast", out_wlast, el);
    check("out_wready_mst", out_wready_mst, erdy);
    check("out_wid", out_wid, eid);
    check("out_wdata", out_wdata, edata);
    check("out_wstrb", out_wstrb, estrb);
    check("aw_push_ready", aw_push_ready, epr);
    check("ostd_cnt", ostd_cnt, mq.size());
    check("wlast_err", wlast_err, merr);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge aclk);
    #1;
    cyc++;
    for (int m = 0; m < MST; m++) begin
      in_wdata[m*DW +: DW]   = {8'(8'hD0 + m), 8'(cyc), 16'(cyc * 7 + m)};
      in_wid[m*IDW +: IDW]   = IDW'(m + cyc);
      in_wstrb[m*SW +: SW]   = SW'(cyc + 3 * m);
      if (auto_wlast)
        in_wlast[m] = (mq.size() > 0) && (mq[0].mst == m) && (done == mq[0].len);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_push(input bit v, input int m, input int l);
    aw_push_valid = v;
    aw_push_mst   = 2'(m);
    aw_push_len   = 4'(l);
  endtask

  logic [3:0] t2_wr [7];
  logic       t2_wl [7];
  int         t2_pm [3];
  int         t2_pl [3];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    aw_push_valid = 1'b0; aw_push_mst = '0; aw_push_len = '0;
    in_wvalid = '0; in_wlast = '0; in_wid = '0; in_wdata = '0; in_wstrb = '0;
    in_wready = 1'b0;
    #1 aresetn = 1'b0;

    // Reset
    step(); step();
    settle();
    check("rst_push_ready", aw_push_ready, 1'b0);
    check("rst_ostd", ostd_cnt, 3'd0);
    check("rst_wready", out_wready_mst, 4'b0000);
    aresetn = 1'b1;
    step();
    settle();
    check("rel_push_ready", aw_push_ready, 1'b1);

    // Test 1: single len=3 burst from master 2
    set_push(1, 2, 3); in_wvalid = 4'b0100; in_wready = 1'b1;
    settle();
    check("t1_no_bypass", out_wvalid, 1'b0);
    step();
    set_push(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("t1_wvalid", out_wvalid, 1'b1);
      check("t1_wlast", out_wlast, (i == 3));
      check("t1_ostd", ostd_cnt, 3'd1);
      check("t1_wdata_m2", out_wdata[31:24], 8'hD2);
      step();
    end
    settle();
    check("t1_wvalid_end", out_wvalid, 1'b0);
    check("t1_ostd_end", ostd_cnt, 3'd0);
    check("t1_err", wlast_err, 1'b0);

    // Test 2: ordered bursts m1(2) m3(1) m1(3), all masters valid
    t2_pm = '{1, 3, 1};
    t2_pl = '{1, 0, 2};
    t2_wr = '{4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    t2_wl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    in_wvalid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k < 3) set_push(1, t2_pm[k], t2_pl[k]);
      else       set_push(0, 0, 0);
      settle();
      if (k > 0) begin
        check("t2_wready_mst", out_wready_mst, t2_wr[k-1]);
        check("t2_wlast", out_wlast, t2_wl[k-1]);
      end
      step();
    end

    // Test 3: fill, ready drop, pop frees, push+pop same cycle
    in_wvalid = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      set_push(1, k, k % 2);
      step();
    end
    set_push(0, 0, 0);
    settle();
    check("t3_full_ostd", ostd_cnt, 3'd4);
    check("t3_full_ready", aw_push_ready, 1'b0);
    in_wvalid = 4'b0001;
    settle();
    check("t3_len0_wlast", out_wlast, 1'b1);
    check("t3_ready_no_pop_dep", aw_push_ready, 1'b0);
    step();
    in_wvalid = 4'b0000;
    settle();
    check("t3_after_pop_ostd", ostd_cnt, 3'd3);
    check("t3_after_pop_ready", aw_push_ready, 1'b1);
    in_wvalid = 4'b0010;
    step();
    set_push(1, 2, 2);
    settle();
    check("t3_pushpop_wlast", out_wlast, 1'b1);
    step();
    set_push(0, 0, 0); in_wvalid = 4'b0000;
    settle();
    check("t3_pushpop_ostd", ostd_cnt, 3'd3);
    in_wvalid = 4'b1111;
    for (int k = 0; k < 20 && ostd_cnt != 0; k++) step();
    settle();
    check("t3_drain", ostd_cnt, 3'd0);

    // Test 4: backpressure on a len=3 burst
    set_push(1, 0, 3); in_wvalid = 4'b0001; in_wready = 1'b1;
    step();
    set_push(0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      in_wready = (k % 2 == 0);
      settle();
      if (k % 2 == 1) begin
        check("t4_stall_wvalid", out_wvalid, 1'b1);
        check("t4_stall_wready", out_wready_mst, 4'b0000);
      end
      step();
    end
    in_wready = 1'b1;
    settle();
    check("t4_done_ostd", ostd_cnt, 3'd0);

    // Test 5: early WLAST from master 0
    auto_wlast = 1'b0; in_wlast = '0;
    set_push(1, 0, 3); in_wvalid = 4'b0001;
    step();
    set_push(0, 0, 0);
    settle();
    check("t5_err_b1", wlast_err, 1'b0);
    step();
    in_wlast = 4'b0001;
    settle();
    check("t5_err_b2_pre", wlast_err, 1'b0);
    step();
    in_wlast = 4'b0000;
    settle();
    check("t5_err_set", wlast_err, 1'b1);
    step();
    settle();
    check("t5_b4_wlast", out_wlast, 1'b1);
    step();
    settle();
    check("t5_err_sticky", wlast_err, 1'b1);
    check("t5_done_ostd", ostd_cnt, 3'd0);
    auto_wlast = 1'b1;

    // Test 6: reset during a len=7 burst with 3 entries queued
    in_wvalid = 4'b0010;
    set_push(1, 1, 7); step();
    set_push(1, 2, 1); step();
    set_push(1, 3, 0); step();
    set_push(1, 0, 2); step();
    set_push(0, 0, 0);
    settle();
    check("t6_ostd_pre", ostd_cnt, 3'd4);
    aresetn = 1'b0;
    settle();
    check("t6_rst_wvalid", out_wvalid, 1'b0);
    check("t6_rst_wready", out_wready_mst, 4'b0000);
    check("t6_rst_ostd", ostd_cnt, 3'd0);
    check("t6_rst_push_ready", aw_push_ready, 1'b0);
    check("t6_rst_err", wlast_err, 1'b0);
    step(); step();
    aresetn = 1'b1;
    settle();
    check("t6_rel_ready_pre", aw_push_ready, 1'b0);
    step();
    settle();
    check("t6_rel_ready", aw_push_ready, 1'b1);
    check("t6_rel_ostd", ostd_cnt, 3'd0);
    check("t6_rel_err", wlast_err, 1'b0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
